// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-port arbiter and sequencer in front of the 1 KiB big-endian data memory.
//   Port 0 is the pipeline MEM stage, port 1 the debug/loader master. At most
//   one 64-bit access is granted per cycle; the granted port alone drives the
//   memory, the address is range-checked, and a registered response returns
//   to the granted port one cycle after the grant.
//
// Ports
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   mN_req/we/addr/wdata       request from port N, held stable until mN_gnt
//   mN_gnt                     request accepted this cycle (combinational)
//   mN_rsp_valid               one-cycle response pulse, the cycle after mN_gnt
//   mN_rdata, mN_err           read data (0 for writes/errors), range error;
//                              both hold until the next response to port N
//   MemRead, MemWrite          memory strobes (never set for out-of-range access)
//   address, write_data        memory address / write data (0 when idle)
//   read_data                  combinational read data from the memory
//
// Parameters
//   MEM_BYTES  memory size; a legal access needs addr+7 < MEM_BYTES
//   PRIO_MODE  0 = round-robin, 1 = fixed priority to port 0 with starvation guard
//   MAX_WAIT   fixed mode: consecutive denied cycles before port 1 is force-granted
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int MEM_BYTES = 1024,
    parameter int PRIO_MODE = 0,
    parameter int MAX_WAIT  = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [63:0] m0_addr,
    input  logic [63:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rsp_valid,
    output logic [63:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [63:0] m1_addr,
    input  logic [63:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rsp_valid,
    output logic [63:0] m1_rdata,
    output logic        m1_err,

    output logic        MemRead,
    output logic        MemWrite,
    output logic [63:0] address,
    output logic [63:0] write_data,
    input  logic [63:0] read_data
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    localparam int                  WAIT_W     = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0]   WAIT_MAX   = WAIT_W'(MAX_WAIT);
    // Highest start address whose 8-byte access still fits in the memory.
    localparam logic [63:0]         LAST_LEGAL = 64'(MEM_BYTES - 8);

    port_e             last_owner;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        rsp_valid_q;

    logic              pick1;       // a contested cycle goes to port 1
    logic              any_gnt;
    logic              sel_we;
    logic [63:0]       sel_addr;
    logic [63:0]       sel_wdata;
    logic              in_range;
    logic [63:0]       rsp_data;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        pick1 = 1'b0;
        if (PRIO_MODE == 0) begin
            pick1 = (last_owner == PORT0);
        end else begin
            pick1 = (wait_cnt == WAIT_MAX);
        end
    end

    // Grants are forced low during reset so an access coinciding with reset
    // never reaches the memory.
    assign m0_gnt  = !reset && m0_req && (!m1_req || !pick1);
    assign m1_gnt  = !reset && m1_req && (!m0_req || pick1);
    assign any_gnt = m0_gnt || m1_gnt;

    // -------------------------------------------------------------------------
    // Issue: only the granted port drives the memory; idle cycles drive zeros.
    // -------------------------------------------------------------------------
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (m0_gnt) begin
            sel_we    = m0_we;
            sel_addr  = m0_addr;
            sel_wdata = m0_wdata;
        end else if (m1_gnt) begin
            sel_we    = m1_we;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end
    end

    // A full 64-bit compare covers both the upper-bits-zero and the
    // last-legal-offset conditions at once.
    assign in_range   = (sel_addr <= LAST_LEGAL);

    assign MemRead    = any_gnt && in_range && !sel_we;
    assign MemWrite   = any_gnt && in_range &&  sel_we;
    assign address    = sel_addr;
    assign write_data = sel_wdata;

    // Writes and errors return zero data.
    assign rsp_data   = (in_range && !sel_we) ? read_data : '0;

    // -------------------------------------------------------------------------
    // State and registered responses
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner  <= PORT1;   // port 0 wins the first contest
            wait_cnt    <= '0;
            rsp_valid_q <= '0;
            m0_rdata    <= '0;
            m0_err      <= 1'b0;
            m1_rdata    <= '0;
            m1_err      <= 1'b0;
        end else begin
            if (m0_gnt) begin
                last_owner <= PORT0;
            end else if (m1_gnt) begin
                last_owner <= PORT1;
            end

            // Starvation counter: consecutive cycles port 1 waited in vain.
            if (!m1_req || m1_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            rsp_valid_q <= {m1_gnt, m0_gnt};

            if (m0_gnt) begin
                m0_rdata <= rsp_data;
                m0_err   <= !in_range;
            end
            if (m1_gnt) begin
                m1_rdata <= rsp_data;
                m1_err   <= !in_range;
            end
        end
    end

    // A response pending when reset arrives is suppressed immediately rather
    // than one cycle later.
    assign m0_rsp_valid = rsp_valid_q[0] && !reset;
    assign m1_rsp_valid = rsp_valid_q[1] && !reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Two instances: u_rr (round-robin, ports 0/1, memory 0) and u_fix (fixed
//   priority, ports 2/3, memory 1). Each has a behavioural big-endian memory.
//   A transaction-level reference (who should win, what each access returns)
//   is evaluated every cycle, plus directed scenarios with literal expectations.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    localparam int MEM_BYTES = 1024;
    localparam int MAX_WAIT  = 8;

    logic clk = 1'b0;
    logic reset;

    logic [3:0]        req;
    logic [3:0]        wr;
    logic [3:0][63:0]  addr;
    logic [3:0][63:0]  wdata;
    wire  [3:0]        gnt;
    wire  [3:0]        rsp;
    wire  [3:0]        err;
    wire  [3:0][63:0]  rdata;

    wire  [1:0]        mem_rd;
    wire  [1:0]        mem_wr;
    wire  [1:0][63:0]  mem_addr;
    wire  [1:0][63:0]  mem_wdata;
    logic [1:0][63:0]  mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .PRIO_MODE(0), .MAX_WAIT(MAX_WAIT)) u_rr (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m0_we(wr[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_gnt(gnt[0]), .m0_rsp_valid(rsp[0]), .m0_rdata(rdata[0]), .m0_err(err[0]),
        .m1_req(req[1]), .m1_we(wr[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_gnt(gnt[1]), .m1_rsp_valid(rsp[1]), .m1_rdata(rdata[1]), .m1_err(err[1]),
        .MemRead(mem_rd[0]), .MemWrite(mem_wr[0]), .address(mem_addr[0]),
        .write_data(mem_wdata[0]), .read_data(mem_rdata[0])
    );

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .PRIO_MODE(1), .MAX_WAIT(MAX_WAIT)) u_fix (
        .clk(clk), .reset(reset),
        .m0_req(req[2]), .m0_we(wr[2]), .m0_addr(addr[2]), .m0_wdata(wdata[2]),
        .m0_gnt(gnt[2]), .m0_rsp_valid(rsp[2]), .m0_rdata(rdata[2]), .m0_err(err[2]),
        .m1_req(req[3]), .m1_we(wr[3]), .m1_addr(addr[3]), .m1_wdata(wdata[3]),
        .m1_gnt(gnt[3]), .m1_rsp_valid(rsp[3]), .m1_rdata(rdata[3]), .m1_err(err[3]),
        .MemRead(mem_rd[1]), .MemWrite(mem_wr[1]), .address(mem_addr[1]),
        .write_data(mem_wdata[1]), .read_data(mem_rdata[1])
    );

    // -------------------------------------------------------------------------
    // Behavioural memories: big-endian, combinational read, synchronous write.
    // Unwritten bytes read as a fixed address-derived pattern.
    // -------------------------------------------------------------------------
    logic [7:0] env_mem [2][MEM_BYTES];
    bit         env_set [2][MEM_BYTES];

    function automatic logic [7:0] init_byte(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    function automatic logic [63:0] init_word(input int a);
        logic [63:0] v;
        for (int b = 0; b < 8; b++) v[63-8*b -: 8] = init_byte(a + b);
        return v;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_wr[d] && mem_addr[d] <= 64'(MEM_BYTES - 8)) begin
                for (int b = 0; b < 8; b++) begin
                    env_mem[d][int'(mem_addr[d][9:0]) + b] <= mem_wdata[d][63-8*b -: 8];
                    env_set[d][int'(mem_addr[d][9:0]) + b] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            mem_rdata[d] = 64'hBAD0_BAD0_BAD0_BAD0;
            if (mem_addr[d] <= 64'(MEM_BYTES - 8)) begin
                for (int b = 0; b < 8; b++) begin
                    mem_rdata[d][63-8*b -: 8] = env_set[d][int'(mem_addr[d][9:0]) + b]
                        ? env_mem[d][int'(mem_addr[d][9:0]) + b]
                        : init_byte(int'(mem_addr[d][9:0]) + b);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Reference model (transaction level)
    // -------------------------------------------------------------------------
    logic [7:0]  ref_mem [2][MEM_BYTES];
    int          m_last [2];       // port that won most recently
    int          m_wait [2];       // consecutive denied cycles of port 1
    logic        cur_rv    [4];    // expected outputs for the current cycle
    logic [63:0] cur_rdata [4];
    logic        cur_err   [4];
    logic        pg        [4];    // predicted grant of the last checked cycle
    bit          armed = 1'b0;

    function automatic bit legal(input logic [63:0] a);
        return (a < 64'(MEM_BYTES)) && (a + 64'd7 < 64'(MEM_BYTES));
    endfunction

    function automatic logic [63:0] ref_read(input int d, input logic [63:0] a);
        logic [63:0] v;
        for (int b = 0; b < 8; b++) v[63-8*b -: 8] = ref_mem[d][int'(a[9:0]) + b];
        return v;
    endfunction

    task automatic ref_write(input int d, input logic [63:0] a, input logic [63:0] v);
        for (int b = 0; b < 8; b++) ref_mem[d][int'(a[9:0]) + b] = v[63-8*b -: 8];
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called mid-cycle: compare outputs with the model, then advance the model.
    task automatic check_cycle();
        bit arm_next;
        arm_next = 1'b0;
        for (int d = 0; d < 2; d++) begin
            int          w;
            logic        r0, r1, lg, wrq;
            logic [63:0] a;
            w   = -1;
            r0  = req[2*d];
            r1  = req[2*d+1];
            a   = 64'd0;
            lg  = 1'b0;
            wrq = 1'b0;
            if (!reset) begin
                if (r0 && r1) begin
                    if (d == 0) w = (m_last[d] == 0) ? 1 : 0;
                    else        w = (m_wait[d] >= MAX_WAIT) ? 1 : 0;
                end else if (r0) begin
                    w = 0;
                end else if (r1) begin
                    w = 1;
                end
            end
            if (w >= 0) begin
                a   = addr[2*d+w];
                wrq = wr[2*d+w];
                lg  = legal(a);
            end

            if (armed) begin
                for (int p = 0; p < 2; p++) begin
                    check($sformatf("d%0d.p%0d.gnt", d, p), gnt[2*d+p], (w == p));
                    check($sformatf("d%0d.p%0d.rsp_valid", d, p), rsp[2*d+p],
                          reset ? 1'b0 : cur_rv[2*d+p]);
                    check($sformatf("d%0d.p%0d.rdata", d, p), rdata[2*d+p], cur_rdata[2*d+p]);
                    check($sformatf("d%0d.p%0d.err", d, p), err[2*d+p], cur_err[2*d+p]);
                end
                check($sformatf("d%0d.MemRead", d), mem_rd[d], lg && !wrq);
                check($sformatf("d%0d.MemWrite", d), mem_wr[d], lg && wrq);
                if (w < 0) begin
                    check($sformatf("d%0d.address_idle", d), mem_addr[d], 64'd0);
                    check($sformatf("d%0d.write_data_idle", d), mem_wdata[d], 64'd0);
                end else if (lg) begin
                    check($sformatf("d%0d.address", d), mem_addr[d], a);
                    if (wrq) check($sformatf("d%0d.write_data", d), mem_wdata[d], wdata[2*d+w]);
                end
            end

            if (reset) begin
                arm_next  = 1'b1;
                m_last[d] = 1;
                m_wait[d] = 0;
                for (int p = 0; p < 2; p++) begin
                    cur_rv[2*d+p]    = 1'b0;
                    cur_rdata[2*d+p] = 64'd0;
                    cur_err[2*d+p]   = 1'b0;
                    pg[2*d+p]        = 1'b0;
                end
            end else begin
                for (int p = 0; p < 2; p++) begin
                    cur_rv[2*d+p] = (w == p);
                    pg[2*d+p]     = (w == p);
                end
                if (w >= 0) begin
                    cur_err[2*d+w]   = !lg;
                    cur_rdata[2*d+w] = (lg && !wrq) ? ref_read(d, a) : 64'd0;
                    if (lg && wrq) ref_write(d, a, wdata[2*d+w]);
                    m_last[d] = w;
                end
                if (!r1 || w == 1)          m_wait[d] = 0;
                else if (m_wait[d] < MAX_WAIT) m_wait[d]++;
            end
        end
        if (arm_next) armed = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic r, input logic w,
                         input logic [63:0] a, input logic [63:0] v);
        req[i] = r; wr[i] = w; addr[i] = a; wdata[i] = v;
    endtask

    task automatic one_access(input int i, input logic w, input logic [63:0] a,
                              input logic [63:0] v, input string tag);
        drive(i, 1'b1, w, a, v);
        #1;
        check({tag, ".gnt"}, gnt[i], 1'b1);
        tick();
        drive(i, 1'b0, 1'b0, 64'd0, 64'd0);
    endtask

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 64'(1017 + $urandom_range(0, 6));
            1:       return 64'h400 | 64'($urandom_range(0, 1023));
            2:       return {32'($urandom), 32'($urandom)};
            3, 4, 5: return 64'($urandom_range(0, 7) * 8);
            default: return 64'($urandom_range(0, MEM_BYTES - 8));
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------------
    localparam logic [63:0] W1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] W4 = 64'hA5A5_0000_1234_5678;
    localparam logic [63:0] W6 = 64'h0F0E_0D0C_0B0A_0908;

    initial begin
        int n0, n1;
        logic [1:0] g;

        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < MEM_BYTES; a++) ref_mem[d][a] = init_byte(a);
            m_last[d] = 1;
            m_wait[d] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            cur_rv[i] = 1'b0; cur_rdata[i] = 64'd0; cur_err[i] = 1'b0; pg[i] = 1'b0;
            drive(i, 1'b0, 1'b0, 64'd0, 64'd0);
        end
        reset = 1'b1;
        tick();
        tick();
        // Reset state, sampled while reset is still held.
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset.gnt%0d", i), gnt[i], 1'b0);
            check($sformatf("reset.rsp%0d", i), rsp[i], 1'b0);
            check($sformatf("reset.rdata%0d", i), rdata[i], 64'd0);
            check($sformatf("reset.err%0d", i), err[i], 1'b0);
        end
        reset = 1'b0;

        // Round-robin contest: grants alternate 0,1,0,1; two pulses each.
        drive(0, 1'b1, 1'b0, 64'h10, 64'd0);
        drive(1, 1'b1, 1'b0, 64'h20, 64'd0);
        #1;
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr.gnt_k%0d", k), gnt[1:0], (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            n0 += int'(rsp[0]);
            n1 += int'(rsp[1]);
        end
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
        check("rr.pulses_p0", 64'(n0), 64'd2);
        check("rr.pulses_p1", 64'(n1), 64'd2);

        // Write then read back-to-back on port 0.
        one_access(0, 1'b1, 64'h10, W1, "wr10");
        check("wr10.rsp", rsp[0], 1'b1);
        check("wr10.rdata", rdata[0], 64'd0);
        check("wr10.err", err[0], 1'b0);
        one_access(0, 1'b0, 64'h10, 64'd0, "rd10");
        check("rd10.rsp", rsp[0], 1'b1);
        check("rd10.rdata", rdata[0], W1);
        check("rd10.err", err[0], 1'b0);

        // Range boundary.
        one_access(0, 1'b1, 64'h3F8, W4, "wr3f8");
        one_access(0, 1'b0, 64'h3F8, 64'd0, "rd3f8");
        check("rd3f8.rdata", rdata[0], W4);
        check("rd3f8.err", err[0], 1'b0);
        drive(0, 1'b1, 1'b0, 64'h3F9, 64'd0);
        #1;
        check("rd3f9.MemRead", mem_rd[0], 1'b0);
        tick();
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        check("rd3f9.rsp", rsp[0], 1'b1);
        check("rd3f9.err", err[0], 1'b1);
        check("rd3f9.rdata", rdata[0], 64'd0);
        one_access(0, 1'b0, 64'h400, 64'd0, "rd400");
        check("rd400.err", err[0], 1'b1);
        check("rd400.rdata", rdata[0], 64'd0);

        // Out-of-range write from port 1 must not touch memory.
        drive(1, 1'b1, 1'b1, 64'h7F8, 64'hFFFF_FFFF_FFFF_FFFF);
        #1;
        check("wr7f8.gnt", gnt[1], 1'b1);
        check("wr7f8.MemWrite", mem_wr[0], 1'b0);
        tick();
        drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
        check("wr7f8.err", err[1], 1'b1);
        one_access(0, 1'b0, 64'h3F8, 64'd0, "rd3f8_again");
        check("rd3f8_again.rdata", rdata[0], W4);

        // Reset the cycle after a read grant; write during reset is not issued.
        one_access(0, 1'b1, 64'h40, W6, "wr40");
        one_access(0, 1'b0, 64'h40, 64'd0, "rd40");
        reset = 1'b1;
        drive(0, 1'b1, 1'b1, 64'h48, 64'hDEAD_BEEF_0000_0001);
        #1;
        check("rst.rsp_same_cycle", rsp[0], 1'b0);
        check("rst.gnt", gnt[0], 1'b0);
        check("rst.MemWrite", mem_wr[0], 1'b0);
        tick();
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        #1;
        check("rst.rsp_next_cycle", rsp[0], 1'b0);
        check("rst.rdata_cleared", rdata[0], 64'd0);
        one_access(0, 1'b0, 64'h40, 64'd0, "rd40_after_rst");
        check("rd40_after_rst.rdata", rdata[0], W6);
        one_access(0, 1'b0, 64'h48, 64'd0, "rd48_after_rst");
        check("rd48_after_rst.rdata", rdata[0], init_word(32'h48));

        // Fixed priority: port 0 wins 8 cycles, port 1 forced on the 9th,
        // then the guard starts over and port 0 wins again.
        drive(2, 1'b1, 1'b0, 64'h100, 64'd0);
        drive(3, 1'b1, 1'b0, 64'h108, 64'd0);
        #1;
        for (int k = 0; k < 10; k++) begin
            g = gnt[3:2];
            check($sformatf("fix.gnt_k%0d", k), g, (k == 8) ? 2'b10 : 2'b01);
            tick();
        end
        drive(2, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(3, 1'b0, 1'b0, 64'd0, 64'd0);
        tick();

        // Randomized traffic on both instances with occasional resets.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i] || pg[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b0;
                    end else begin
                        drive(i, 1'b1, 1'($urandom_range(0, 1)), rand_addr(),
                              {32'($urandom), 32'($urandom)});
                    end
                end
            end
            reset = ($urandom_range(0, 63) == 0);
            tick();
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 1'b0, 64'd0, 64'd0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
